// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI-lite request arbiter: FSM states, latched command, default widths.
package axi_arb_pkg;

  localparam int ARB_NUM_REQ    = 2;
  localparam int ARB_ADDR_W     = 32;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_TIMEOUT    = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Sized for AXI-lite (32-bit address/data); narrower instances zero-extend into it.
  typedef struct packed {
    logic                  write;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_cmd_t;

  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, modulo NUM_REQ.
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cand
    assign cand[i] = IDX_W'(rr_wrap(int'(ptr), i, NUM_REQ));
  end

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && valid[cand[i]]) begin
        any            = 1'b1;
        grant[cand[i]] = 1'b1;
        idx            = cand[i];
      end
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Round-robin share of one AXI-lite master command port, one transaction in flight.
// Optional WAIT watchdog (rsp_err on expiry) enabled by defining ARB_TIMEOUT_EN.
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ        = ARB_NUM_REQ,
  parameter int ADDR_W         = ARB_ADDR_W,
  parameter int DATA_W         = ARB_DATA_W,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      start_write,
  output logic                      start_read,
  output logic [ADDR_W-1:0]         write_address,
  output logic [DATA_W-1:0]         write_data,
  output logic [ADDR_W-1:0]         read_address,
  input  logic                      write_done,
  input  logic                      read_done,
  input  logic [DATA_W-1:0]         read_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  arb_cmd_t           cmd_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx_q;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               done_match;
  logic               timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign done_match = cmd_q.write ? write_done : read_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_match || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q       <= '0;
      rr_ptr      <= '0;
      win_idx_q   <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
    end else begin
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            cmd_q.write <= req_write[pick_idx];
            cmd_q.addr  <= ARB_ADDR_W'(sel_addr);
            cmd_q.wdata <= req_write[pick_idx] ? ARB_DATA_W'(sel_wdata) : '0;
            win_idx_q   <= pick_idx;
            req_ready   <= pick_grant;
          end
        end
        ISSUE: begin
          start_write <= cmd_q.write;
          start_read  <= !cmd_q.write;
        end
        WAIT: begin
          if (done_match || timeout_hit) begin
            rsp_valid <= NUM_REQ'(1) << win_idx_q;
            rsp_rdata <= (done_match && !cmd_q.write) ? read_data : '0;
          end
        end
        RESP: begin
          rr_ptr <= IDX_W'(rr_wrap(int'(win_idx_q), 1, NUM_REQ));
          cmd_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Latch is zero outside a transaction, so these read 0 in IDLE.
  assign write_address = cmd_q.write ? ADDR_W'(cmd_q.addr) : '0;
  assign write_data    = cmd_q.write ? DATA_W'(cmd_q.wdata) : '0;
  assign read_address  = cmd_q.write ? '0 : ADDR_W'(cmd_q.addr);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign timeout_hit = (state_q == WAIT) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      wd_cnt  <= (state_q == WAIT) ? wd_cnt + 16'd1 : 16'd0;
      rsp_err <= (state_q == WAIT) && !done_match && timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: cycle vector table plus hand-written arbitration/reset sequences.
module tb_axi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, write_address, write_data, read_address, read_data;
  logic        rsp_err, start_write, start_read, write_done, read_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_req_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .start_write(start_write), .start_read(start_read),
    .write_address(write_address), .write_data(write_data), .read_address(read_address),
    .write_done(write_done), .read_done(read_done), .read_data(read_data)
  );

  typedef struct {
    logic [1:0]  rv, rw;
    logic [31:0] a0, a1, d0, d1;
    logic        wd, rd;
    logic [31:0] rdat;
    logic [1:0]  e_rdy, e_rsp;
    logic [31:0] e_rdata;
    logic        e_sw, e_sr;
    logic [31:0] e_waddr, e_wdat, e_raddr;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    write_done = 1'b0; read_done = 1'b0; read_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(output logic [1:0] g);
    g = '0;
    for (int n = 0; n < 20; n++) begin
      tick();
      g = req_ready;
      if (g != 2'b00) break;
    end
  endtask

  // One complete transaction; keep selects which granted requesters stay valid.
  task automatic serve(input logic [1:0] exp_g, input logic [1:0] keep, input string tag);
    logic [1:0] g;
    wait_ready(g);
    check({tag, " grant"}, 64'(g), 64'(exp_g));
    req_valid = (req_valid & ~g) | (g & keep);
    tick();
    check({tag, " start"}, 64'(start_write | start_read), 64'd1);
    if (start_write) write_done = 1'b1;
    else             read_done  = 1'b1;
    tick();
    write_done = 1'b0;
    read_done  = 1'b0;
    check({tag, " rsp"}, 64'(rsp_valid), 64'(g));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    logic [1:0] seen;
    int         n;

    // rv rw a0 a1 d0 d1 wd rd rdat | rdy rsp rdata sw sr waddr wdat raddr
    vt[0]  = '{2'b01, 2'b01, 32'h20, '0, 32'h04, '0, 1'b0, 1'b0, '0,
               2'b01, 2'b00, '0, 1'b0, 1'b0, 32'h20, 32'h04, '0};
    vt[1]  = '{2'b00, 2'b01, 32'h20, '0, 32'h04, '0, 1'b1, 1'b0, '0,
               2'b00, 2'b00, '0, 1'b1, 1'b0, 32'h20, 32'h04, '0};
    vt[2]  = '{2'b00, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0, '0,
               2'b00, 2'b00, '0, 1'b0, 1'b0, 32'h20, 32'h04, '0};
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = '{2'b00, 2'b00, '0, '0, '0, '0, 1'b1, 1'b0, '0,
               2'b00, 2'b01, '0, 1'b0, 1'b0, 32'h20, 32'h04, '0};
    vt[6]  = '{2'b00, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0, '0,
               2'b00, 2'b00, '0, 1'b0, 1'b0, '0, '0, '0};
    vt[7]  = '{2'b10, 2'b00, '0, 32'h04, '0, 32'h99, 1'b0, 1'b0, '0,
               2'b10, 2'b00, '0, 1'b0, 1'b0, '0, '0, 32'h04};
    vt[8]  = '{2'b00, 2'b00, '0, 32'h04, '0, '0, 1'b0, 1'b0, '0,
               2'b00, 2'b00, '0, 1'b0, 1'b1, '0, '0, 32'h04};
    vt[9]  = '{2'b00, 2'b00, '0, '0, '0, '0, 1'b1, 1'b0, '0,
               2'b00, 2'b00, '0, 1'b0, 1'b0, '0, '0, 32'h04};
    vt[10] = '{2'b00, 2'b00, '0, '0, '0, '0, 1'b0, 1'b1, 32'hA5,
               2'b00, 2'b10, 32'hA5, 1'b0, 1'b0, '0, '0, 32'h04};
    vt[11] = '{2'b00, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 32'h77,
               2'b00, 2'b00, '0, 1'b0, 1'b0, '0, '0, '0};

    do_reset();
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset start", 64'({start_write, start_read}), 64'd0);
    check("reset write_address", 64'(write_address), 64'd0);
    check("reset read_address", 64'(read_address), 64'd0);

    // Tests 1 and 2: write from req0, then read from req1 with a stray write_done.
    for (int i = 0; i < 12; i++) begin
      req_valid  = vt[i].rv;
      req_write  = vt[i].rw;
      req_addr   = {vt[i].a1, vt[i].a0};
      req_wdata  = {vt[i].d1, vt[i].d0};
      write_done = vt[i].wd;
      read_done  = vt[i].rd;
      read_data  = vt[i].rdat;
      tick();
      check($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vt[i].e_rdy));
      check($sformatf("v%0d rsp_valid", i), 64'(rsp_valid), 64'(vt[i].e_rsp));
      check($sformatf("v%0d rsp_rdata", i), 64'(rsp_rdata), 64'(vt[i].e_rdata));
      check($sformatf("v%0d rsp_err", i), 64'(rsp_err), 64'd0);
      check($sformatf("v%0d start_write", i), 64'(start_write), 64'(vt[i].e_sw));
      check($sformatf("v%0d start_read", i), 64'(start_read), 64'(vt[i].e_sr));
      check($sformatf("v%0d write_address", i), 64'(write_address), 64'(vt[i].e_waddr));
      check($sformatf("v%0d write_data", i), 64'(write_data), 64'(vt[i].e_wdat));
      check($sformatf("v%0d read_address", i), 64'(read_address), 64'(vt[i].e_raddr));
    end
    write_done = 1'b0;
    read_done  = 1'b0;

    // Test 3: both valid after reset -> 0 then 1, pointer back at 0.
    do_reset();
    req_write = 2'b11;
    req_valid = 2'b11;
    serve(2'b01, 2'b00, "t3 first");
    serve(2'b10, 2'b00, "t3 second");
    req_valid = 2'b11;
    serve(2'b01, 2'b00, "t3 wrap");

    // Test 4: req0 held valid throughout, req1 raised once -> 0,1,0.
    do_reset();
    req_write = 2'b11;
    req_valid = 2'b01;
    serve(2'b01, 2'b01, "t4 a");
    req_valid = 2'b11;
    serve(2'b10, 2'b01, "t4 b");
    serve(2'b01, 2'b01, "t4 c");

    // Test 5: pointer is now 1; abandon a read from req0 by resetting in WAIT.
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr  = {32'h0, 32'h44};
    wait_ready(g);
    check("t5 grant", 64'(g), 64'b01);
    req_valid = 2'b00;
    tick();
    tick();
    check("t5 read_address in WAIT", 64'(read_address), 64'h44);
    #2 rst = 1'b1;
    #1;
    check("t5 async read_address", 64'(read_address), 64'd0);
    check("t5 async req_ready/rsp_valid", 64'({req_ready, rsp_valid}), 64'd0);
    check("t5 async start", 64'({start_write, start_read}), 64'd0);
    read_done = 1'b1;
    read_data = 32'h5A;
    tick();
    read_done = 1'b0;
    rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    check("t5 no rsp after reset", 64'(seen), 64'd0);
    req_write = 2'b11;
    req_valid = 2'b11;
    serve(2'b01, 2'b00, "t5 after reset");
    serve(2'b10, 2'b00, "t5 follow");

`ifdef ARB_TIMEOUT_EN
    // Test 6: no done ever -> timeout response after 16 WAIT cycles.
    req_write = 2'b01;
    req_valid = 2'b01;
    wait_ready(g);
    check("t6 grant", 64'(g), 64'b01);
    req_valid = 2'b00;
    tick();
    n = 0;
    while (rsp_valid == 2'b00 && n < 40) begin
      tick();
      n++;
    end
    check("t6 wait cycles", 64'(n), 64'd16);
    check("t6 rsp_valid", 64'(rsp_valid), 64'b01);
    check("t6 rsp_err", 64'(rsp_err), 64'd1);
    check("t6 rsp_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    write_done = 1'b1;
    tick();
    write_done = 1'b0;
    seen = rsp_valid;
    tick();
    seen = seen | rsp_valid;
    check("t6 stray done ignored", 64'(seen), 64'd0);
`else
    n = 0;
`endif
    check("final rsp_err", 64'(rsp_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
